// File: rtl/ht_sig_gen.sv
// ht_sig_gen: builds the 48-bit 802.11n HT-SIG field (define HT_SIG_GEN_CHECK_EN to reject mcs>76 or stbc==3)
module ht_sig_gen #(
  parameter int CRC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [6:0]  mcs,
  input  logic        cbw40,
  input  logic [15:0] ht_length,
  input  logic        smoothing,
  input  logic        not_sounding,
  input  logic        aggregation,
  input  logic        fec_ldpc,
  input  logic        short_gi,
  input  logic [1:0]  stbc,
  input  logic [1:0]  ness,
  output logic        crc_start,
  output logic [33:0] crc_d,
  input  logic        crc_valid,
  input  logic [7:0]  crc,
  output logic [23:0] sig_word,
  output logic        sig_valid,
  output logic        sig_last,
  input  logic        sig_ready,
  output logic        busy,
  output logic        err
);
  // LOAD is a one-cycle gap so crc_start lands on the second cycle after start
  typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, OUT1, OUT2} state_t;
  state_t st, nxt;
  logic [23:0] sig1_q;
  logic [9:0] sig2_q;
  logic [7:0] crc_q, cnt;
  logic bad, accept, to_hit;
`ifdef HT_SIG_GEN_CHECK_EN
  assign bad = (mcs > 7'd76) || (stbc == 2'b11);
`else
  assign bad = 1'b0;
`endif
  assign accept = (st == IDLE) && start && !bad;
  assign to_hit = cnt == 8'(CRC_TIMEOUT - 1);
  // state register; reset forces IDLE immediately, dropping any partial field
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) st <= IDLE;
    else st <= nxt;
  // next-state: crc_valid beats the timeout when both land on the same edge
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = accept ? LOAD : IDLE;
      LOAD: nxt = REQ;
      REQ: nxt = WAIT;
      WAIT: nxt = crc_valid ? OUT1 : (to_hit ? IDLE : WAIT);
      OUT1: nxt = sig_ready ? OUT2 : OUT1;
      OUT2: nxt = sig_ready ? IDLE : OUT2;
      default: nxt = IDLE;
    endcase
  end
  // field latch, CRC capture, timeout counter and error pulse
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sig1_q <= '0;
      sig2_q <= '0;
      crc_q <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= ((st == IDLE) && start && bad) || ((st == WAIT) && !crc_valid && to_hit);
      cnt <= (st == WAIT) ? cnt + 8'd1 : '0;
      if (accept) begin
        sig1_q <= {ht_length, cbw40, mcs};
        sig2_q <= {ness, short_gi, fec_ldpc, stbc, aggregation, 1'b1, not_sounding, smoothing};
      end
      if ((st == WAIT) && crc_valid) crc_q <= crc;
    end
  // outputs decoded from state so they all drop with reset
  always_comb begin
    busy = st != IDLE;
    crc_start = st == REQ;
    crc_d = {sig2_q, sig1_q};
    sig_valid = (st == OUT1) || (st == OUT2);
    sig_last = st == OUT2;
    sig_word = (st == OUT1) ? sig1_q : (st == OUT2) ? {6'b0, crc_q, sig2_q} : '0;
  end
endmodule

// File: tb/tb_ht_sig_gen.sv
// tb_ht_sig_gen: directed self-checking bench for ht_sig_gen
module tb_ht_sig_gen;
  logic clk = 0, rstn = 0, start = 0, cbw40 = 0, smoothing = 0, not_sounding = 0;
  logic aggregation = 0, fec_ldpc = 0, short_gi = 0, crc_valid = 0, sig_ready = 0;
  logic [6:0] mcs = 0;
  logic [15:0] ht_length = 0;
  logic [1:0] stbc = 0, ness = 0;
  logic [7:0] crc = 0;
  logic crc_start, sig_valid, sig_last, busy, err;
  logic [33:0] crc_d;
  logic [23:0] sig_word;
  logic seen_a, seen_b;
  int errs = 0, checks = 0;

  ht_sig_gen dut (
    .clk(clk), .rstn(rstn), .start(start), .mcs(mcs), .cbw40(cbw40), .ht_length(ht_length),
    .smoothing(smoothing), .not_sounding(not_sounding), .aggregation(aggregation),
    .fec_ldpc(fec_ldpc), .short_gi(short_gi), .stbc(stbc), .ness(ness),
    .crc_start(crc_start), .crc_d(crc_d), .crc_valid(crc_valid), .crc(crc),
    .sig_word(sig_word), .sig_valid(sig_valid), .sig_last(sig_last), .sig_ready(sig_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a();
    mcs = 7'd7; cbw40 = 0; ht_length = 16'h0FA0; smoothing = 1; not_sounding = 1;
    aggregation = 0; fec_ldpc = 0; short_gi = 0; stbc = 2'd0; ness = 2'd0;
  endtask

  task automatic set_b();
    mcs = 7'd21; cbw40 = 1; ht_length = 16'h1234; smoothing = 0; not_sounding = 0;
    aggregation = 1; fec_ldpc = 1; short_gi = 1; stbc = 2'd1; ness = 2'd2;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_crc_start", crc_start, 0);
    chk("rst_crc_d", crc_d, 0);
    chk("rst_sig_word", sig_word, 0);
    chk("rst_sig_valid", sig_valid, 0);
    chk("rst_sig_last", sig_last, 0);
    chk("rst_err", err, 0);
    rstn = 1;
    tick();
    // packing, CRC returned 36 cycles after crc_start
    set_a();
    pulse_start();
    chk("pk_busy", busy, 1);
    chk("pk_crc_start_early", crc_start, 0);
    tick();
    chk("pk_crc_start", crc_start, 1);
    chk("pk_crc_d", crc_d, 34'h0070FA007);
    tick();
    chk("pk_crc_start_once", crc_start, 0);
    tick(35);
    chk("pk_valid_early", sig_valid, 0);
    crc_valid = 1; crc = 8'hA5;
    tick();
    crc_valid = 0; crc = 0;
    chk("pk_valid1", sig_valid, 1);
    chk("pk_word1", sig_word, 24'h0FA007);
    chk("pk_last1", sig_last, 0);
    sig_ready = 1;
    tick();
    chk("pk_valid2", sig_valid, 1);
    chk("pk_word2", sig_word, 24'h029407);
    chk("pk_last2", sig_last, 1);
    tick();
    sig_ready = 0;
    chk("pk_done_valid", sig_valid, 0);
    chk("pk_done_busy", busy, 0);
    chk("pk_done_err", err, 0);
    // backpressure with stray start and crc_valid during the stall
    set_b();
    pulse_start();
    tick();
    chk("bp_crc_start", crc_start, 1);
    chk("bp_crc_d", crc_d, 34'h2DC123495);
    tick();
    crc_valid = 1; crc = 8'h3C;
    tick();
    crc_valid = 0; crc = 0;
    chk("bp_word1", sig_word, 24'h123495);
    seen_a = 0; seen_b = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin set_a(); start = 1; end
      if (i == 5) begin crc_valid = 1; crc = 8'hFF; end
      tick();
      start = 0; crc_valid = 0; crc = 0;
      if (crc_start) seen_a = 1;
      if (sig_word !== 24'h123495 || sig_valid !== 1'b1 || sig_last !== 1'b0 || busy !== 1'b1) seen_b = 1;
    end
    chk("bp_no_crc_start", seen_a, 0);
    chk("bp_stall1_unstable", seen_b, 0);
    chk("bp_crc_d_held", crc_d, 34'h2DC123495);
    sig_ready = 1;
    tick();
    sig_ready = 0;
    chk("bp_word2", sig_word, 24'h00F2DC);
    chk("bp_last2", sig_last, 1);
    seen_b = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sig_word !== 24'h00F2DC || sig_valid !== 1'b1 || sig_last !== 1'b1 || busy !== 1'b1) seen_b = 1;
    end
    chk("bp_stall2_unstable", seen_b, 0);
    sig_ready = 1;
    tick();
    sig_ready = 0;
    chk("bp_done_valid", sig_valid, 0);
    chk("bp_done_busy", busy, 0);
    // timeout with a silent CRC stage
    set_a();
    pulse_start();
    tick(2);
    seen_a = 0; seen_b = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (sig_valid) seen_a = 1;
      if (err) seen_b = 1;
    end
    chk("to_no_valid", seen_a, 0);
    chk("to_no_early_err", seen_b, 0);
    chk("to_busy_before", busy, 1);
    tick();
    chk("to_err", err, 1);
    chk("to_busy_after", busy, 0);
    chk("to_valid_after", sig_valid, 0);
    tick();
    chk("to_err_once", err, 0);
    // crc_valid on the timeout edge wins
    pulse_start();
    tick(2);
    tick(63);
    crc_valid = 1; crc = 8'h5A;
    tick();
    crc_valid = 0; crc = 0;
    chk("tw_err", err, 0);
    chk("tw_valid", sig_valid, 1);
    chk("tw_word1", sig_word, 24'h0FA007);
    sig_ready = 1;
    tick();
    chk("tw_word2", sig_word, 24'h016807);
    tick();
    sig_ready = 0;
    chk("tw_busy", busy, 0);
    // reset during WAIT
    set_b();
    pulse_start();
    tick(5);
    rstn = 0;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_crc_d", crc_d, 0);
    chk("rw_crc_start", crc_start, 0);
    tick();
    rstn = 1;
    tick();
    chk("rw_idle", busy, 0);
    // reset during OUT2
    set_a();
    pulse_start();
    tick(2);
    crc_valid = 1; crc = 8'hA5;
    tick();
    crc_valid = 0; crc = 0;
    sig_ready = 1;
    tick();
    sig_ready = 0;
    chk("ro_last", sig_last, 1);
    rstn = 0;
    #1;
    chk("ro_valid", sig_valid, 0);
    chk("ro_word", sig_word, 0);
    chk("ro_last0", sig_last, 0);
    chk("ro_busy", busy, 0);
    tick();
    rstn = 1;
    tick();
    set_b();
    pulse_start();
    tick();
    chk("ra_crc_start", crc_start, 1);
    chk("ra_crc_d", crc_d, 34'h2DC123495);
    tick();
    crc_valid = 1; crc = 8'h3C;
    tick();
    crc_valid = 0; crc = 0;
    chk("ra_word1", sig_word, 24'h123495);
    sig_ready = 1;
    tick();
    chk("ra_word2", sig_word, 24'h00F2DC);
    tick();
    sig_ready = 0;
    chk("ra_busy", busy, 0);
    // out-of-range MCS
    set_a();
    mcs = 7'd77;
    pulse_start();
`ifdef HT_SIG_GEN_CHECK_EN
    chk("mc_err", err, 1);
    chk("mc_busy", busy, 0);
    seen_a = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (crc_start || busy) seen_a = 1;
    end
    chk("mc_no_req", seen_a, 0);
    chk("mc_err_once", err, 0);
`else
    chk("mc_busy", busy, 1);
    chk("mc_err", err, 0);
    tick();
    chk("mc_crc_start", crc_start, 1);
    chk("mc_crc_d", crc_d, 34'h0070FA04D);
    tick();
    crc_valid = 1; crc = 8'hA5;
    tick();
    crc_valid = 0; crc = 0;
    chk("mc_word1", sig_word, 24'h0FA04D);
    sig_ready = 1;
    tick();
    chk("mc_word2", sig_word, 24'h029407);
    tick();
    sig_ready = 0;
    chk("mc_busy_done", busy, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
